// File: rtl/dcache_responder_pkg.sv
// Shared types for the memory-stage data cache: word and RAM handshake types,
// cache FSM states and the per-frame record.
package dcache_responder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WRITE = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } dcache_state_t;

    // Tag field sized for the smallest legal cache (2 sets); narrower tags are zero-extended.
    localparam int MAX_TAGW = 29;

    typedef struct packed {
        logic                valid;
        logic [MAX_TAGW-1:0] tag;
        word_t               data;
    } dcache_frame_t;

endpackage

// File: rtl/dcache_frame_array.sv
// SETS-entry frame store: combinational read port, one synchronous write port,
// single-cycle invalidate of every valid bit. No backpressure.
module dcache_frame_array
    import dcache_responder_pkg::*;
#(
    parameter int SETS = 16,
    localparam int IDXW = $clog2(SETS)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [IDXW-1:0] ridx,
    output dcache_frame_t   rframe,
    input  logic            we,
    input  logic [IDXW-1:0] widx,
    input  dcache_frame_t   wframe,
    input  logic            invalidate_all
);

    logic [SETS-1:0]     valid;
    logic [MAX_TAGW-1:0] tags  [SETS];
    word_t               datas [SETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (invalidate_all) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= wframe.valid;
        end
    end

    // Tag and data need no reset: they are qualified by the valid bit.
    always_ff @(posedge CLK) begin
        if (we) begin
            tags[widx]  <= wframe.tag;
            datas[widx] <= wframe.data;
        end
    end

    always_comb begin
        rframe.valid = valid[ridx];
        rframe.tag   = tags[ridx];
        rframe.data  = datas[ridx];
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through, no-write-allocate data cache; load hits complete in 0 cycles,
// misses and all stores wait on the RAM arbiter until ACCESS. Requester holds request until dhit.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    input  logic        halt,
    output logic        flushed,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    dcache_state_t       state, next_state;
    logic [IDXW-1:0]     idx;
    logic [MAX_TAGW-1:0] tag;
    dcache_frame_t       rframe, wframe;
    logic                hit, fa_we, invalidate_all, ram_access;
    logic                addr_unused;

    assign idx         = dmemaddr[2+IDXW-1:2];
    assign tag         = MAX_TAGW'(dmemaddr[31:2+IDXW]);
    assign hit         = rframe.valid && (rframe.tag == tag);
    assign ram_access  = (ramstate_t'(ramstate) == ACCESS);
    assign addr_unused = ^dmemaddr[1:0];

    dcache_frame_array #(.SETS(SETS)) u_frames (
        .CLK            (CLK),
        .nRST           (nRST),
        .ridx           (idx),
        .rframe         (rframe),
        .we             (fa_we),
        .widx           (idx),
        .wframe         (wframe),
        .invalidate_all (invalidate_all)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        dhit           = 1'b0;
        dmemload       = '0;
        ramREN         = 1'b0;
        ramWEN         = 1'b0;
        ramaddr        = '0;
        ramstore       = '0;
        fa_we          = 1'b0;
        invalidate_all = 1'b0;
        wframe         = '{valid: 1'b1, tag: tag, data: ramload};
        flushed        = (state == DONE);

        unique case (state)
            IDLE: begin
                // A pending request wins over halt; a store wins over a simultaneous load.
                if (dmemWEN) begin
                    next_state = WRITE;
                end else if (dmemREN) begin
                    if (hit) begin
                        dhit     = 1'b1;
                        dmemload = rframe.data;
                    end else begin
                        next_state = FILL;
                    end
                end else if (halt) begin
                    next_state = FLUSH;
                end
            end
            FILL: begin
                if (!dmemREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = {dmemaddr[31:2], 2'b00};
                    if (ram_access) begin
                        dhit       = 1'b1;
                        dmemload   = ramload;
                        fa_we      = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            WRITE: begin
                if (!dmemWEN) begin
                    next_state = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = {dmemaddr[31:2], 2'b00};
                    ramstore = dmemstore;
                    if (ram_access) begin
                        dhit        = 1'b1;
                        fa_we       = hit;
                        wframe.data = dmemstore;
                        next_state  = IDLE;
                    end
                end
            end
            FLUSH: begin
                invalidate_all = 1'b1;
                next_state     = DONE;
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
